// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external multicycle ALU
// between two requesters. Each requester has a valid/ready request channel
// and a valid/ready response channel. The operand/select lines driven to
// the ALU are registered. The ALU result is captured after a latency that
// depends on the op.
module alu_share_arbiter #(
   parameter int W      = 32,
   parameter int LAT    = 1,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*W-1:0]     req_a,
   input  logic [2*W-1:0]     req_b,
   input  logic [7:0]         req_op,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [W-1:0]       rsp_data,
   output logic [W-1:0]       alu_a,
   output logic [W-1:0]       alu_b,
   output logic [3:0]         alu_sel,
   input  logic [W-1:0]       alu_res,
   output logic               busy,
   output logic [CNT_W-1:0]   ops_done
);

   // The latency counter only has to hold the longest latency minus one.
   localparam int MAX_LAT = (LAT > MD_LAT) ? LAT : MD_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            last_grant;   // requester granted most recently
   logic            gid;          // requester owning the in-flight op
   logic            grant;        // requester that would win this cycle
   logic [CW-1:0]   cnt;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [3:0]      sel_op;
   logic [CW-1:0]   lat_init;

   // Round-robin pick plus the granted requester's payload and its latency.
   always_comb begin
      grant = req_valid[1];
      if (req_valid == 2'b11) grant = ~last_grant;
      sel_a    = grant ? req_a[W +: W]  : req_a[0 +: W];
      sel_b    = grant ? req_b[W +: W]  : req_b[0 +: W];
      sel_op   = grant ? req_op[4 +: 4] : req_op[0 +: 4];
      // mul and div take the long path through the ALU.
      lat_init = ((sel_op == 4'd2) || (sel_op == 4'd3)) ? CW'(MD_LAT - 1)
                                                         : CW'(LAT - 1);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples its inputs from before the edge.
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nx  = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready[grant] = 1'b1;
               state_nx         = EXEC;
            end
         end
         EXEC: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = RESP;
         end
         RESP: begin
            busy           = 1'b1;
            rsp_valid[gid] = 1'b1;
            if (rsp_ready[gid]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand launch, latency countdown, result capture, op count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         gid        <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         rsp_data   <= '0;
         ops_done   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  alu_a      <= sel_a;
                  alu_b      <= sel_b;
                  alu_sel    <= sel_op;
                  gid        <= grant;
                  last_grant <= grant;
                  cnt        <= lat_init;
               end
            end
            EXEC: begin
               if (cnt != '0) cnt      <= cnt - 1'b1;
               else           rsp_data <= alu_res;
            end
            RESP: begin
               if (rsp_ready[gid]) ops_done <= ops_done + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. A behavioural ALU drives alu_res. The
// expected grant order, latency, result and op count come from a simple
// model of the arbiter's rules held in the bench.
module tb_alu_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [7:0]  req_op;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_sel;
   logic [31:0] alu_res;
   logic        busy;
   logic [3:0]  ops_done;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_ops = 0;

   alu_share_arbiter #(.W(32), .LAT(1), .MD_LAT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
      .busy(busy), .ops_done(ops_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The shared ALU: 16 ops selected by a 4-bit code.
   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      case (op)
         4'd0:    alu_model = a + b;
         4'd1:    alu_model = a - b;
         4'd2:    alu_model = a * b;
         4'd3:    alu_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd4:    alu_model = a & b;
         4'd5:    alu_model = a | b;
         4'd6:    alu_model = a ^ b;
         4'd7:    alu_model = ~(a | b);
         4'd8:    alu_model = a >> b[4:0];
         4'd9:    alu_model = $unsigned($signed(a) >>> b[4:0]);
         4'd10:   alu_model = a << b[4:0];
         4'd11:   alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   alu_model = (a < b) ? 32'd1 : 32'd0;
         4'd13:   alu_model = ~a;
         4'd14:   alu_model = b;
         default: alu_model = a;
      endcase
   endfunction

   assign alu_res = alu_model(alu_a, alu_b, alu_sel);

   function automatic int exp_lat(input logic [3:0] op);
      return (op == 4'd2 || op == 4'd3) ? 4 : 1;
   endfunction

   // Reset pulse; leaves the bench one time unit after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      exp_ops = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One request from requester r; returns what was observed. Entered and
   // left one time unit after a rising edge. hold = cycles rsp_ready stays low.
   task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int hold,
                         output logic [1:0] gnt, output logic [1:0] rv,
                         output logic [31:0] data, output int lat,
                         output int busy_n, output bit ok);
      int k;
      ok = 1'b1; gnt = 2'b00; rv = 2'b00; data = '0; lat = 0; busy_n = 0;
      req_a[r*32 +: 32] = a;
      req_b[r*32 +: 32] = b;
      req_op[r*4 +: 4]  = op;
      req_valid[r]      = 1'b1;
      rsp_ready[r]      = (hold == 0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (req_ready == 2'b00 && k < 50);
      if (req_ready == 2'b00) begin
         n_cmp++; n_bad++;
         $display("FAIL grant_timeout: req_ready stayed %b for requester %0d", req_ready, r);
         req_valid[r] = 1'b0;
         ok = 1'b0;
         return;
      end
      gnt = req_ready;
      @(posedge clk);
      #1 req_valid[r] = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || lat >= 50) break;
         lat++;
         if (busy) busy_n++;
      end
      if (rsp_valid == 2'b00) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", lat);
         ok = 1'b0;
         return;
      end
      rv   = rsp_valid;
      data = rsp_data;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1 rsp_ready[r] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      req_valid = 2'b00; rsp_ready = 2'b00;
      req_a = '0; req_b = '0; req_op = '0;
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid, busy, ops_done} !== 9'd0 || rsp_data !== 32'd0 ||
          alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b ops=%0d data=%h a=%h b=%h sel=%h, required all zero",
                  req_ready, rsp_valid, busy, ops_done, rsp_data, alu_a, alu_b, alu_sel);
      end
      do_reset();
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_no_req: req_ready=%b busy=%b, required 00/0", req_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic_add();
      logic [1:0] gnt, rv; logic [31:0] data; int lat, bn; bit ok;
      do_reset();
      run_op(0, 32'd5, 32'd7, 4'd0, 0, gnt, rv, data, lat, bn, ok);
      if (!ok) return;
      exp_ops++;
      n_cmp++;
      if (gnt !== 2'b01 || rv !== 2'b01 || lat !== 1) begin
         n_bad++;
         $display("FAIL add_handshake: gnt=%b rv=%b lat=%0d, required 01/01/1", gnt, rv, lat);
      end
      n_cmp++;
      if (data !== 32'd12) begin
         n_bad++;
         $display("FAIL add_data: got %0d, required 12", data);
      end
      n_cmp++;
      if (ops_done !== 4'(exp_ops) || rsp_valid !== 2'b00 || busy !== 1'b0 || alu_a !== 32'd5) begin
         n_bad++;
         $display("FAIL add_after: ops=%0d vld=%b busy=%b alu_a=%0d, required %0d/00/0/5",
                  ops_done, rsp_valid, busy, alu_a, exp_ops);
      end
   endtask

   task automatic test_round_robin();
      logic exp_last, exp_g;
      logic [31:0] pa, pb;
      int k;
      do_reset();
      exp_last = 1'b1;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      req_op = {4'd6, 4'd6};
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (req_ready == 2'b00 && k < 20);
         exp_g = ~exp_last;
         n_cmp++;
         if (req_ready !== (2'b01 << exp_g)) begin
            n_bad++;
            $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", i, req_ready, 2'b01 << exp_g);
            if (req_ready == 2'b00) break;
         end
         pa = req_a[exp_g*32 +: 32];
         pb = req_b[exp_g*32 +: 32];
         @(posedge clk);
         #1;
         exp_last = exp_g;
         req_a[exp_g*32 +: 32] = $urandom;
         req_b[exp_g*32 +: 32] = $urandom;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (rsp_valid == 2'b00 && k < 20);
         n_cmp++;
         if (rsp_valid !== (2'b01 << exp_g) || rsp_data !== (pa ^ pb)) begin
            n_bad++;
            $display("FAIL rr_rsp[%0d]: vld=%b data=%h, required %b/%h", i, rsp_valid, rsp_data,
                     2'b01 << exp_g, pa ^ pb);
         end
         exp_ops++;
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      n_cmp++;
      if (ops_done !== 4'(exp_ops)) begin
         n_bad++;
         $display("FAIL rr_ops: ops_done=%0d, required %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_muldiv();
      logic [1:0] gnt, rv; logic [31:0] data; int lat, bn; bit ok;
      run_op(0, 32'd6, 32'd7, 4'd2, 0, gnt, rv, data, lat, bn, ok);
      if (ok) begin
         exp_ops++;
         n_cmp++;
         if (lat !== 4 || bn !== 4) begin
            n_bad++;
            $display("FAIL mul_latency: lat=%0d busy_cycles=%0d, required 4/4", lat, bn);
         end
         n_cmp++;
         if (data !== 32'd42) begin
            n_bad++;
            $display("FAIL mul_data: got %0d, required 42", data);
         end
      end
      run_op(1, 32'd42, 32'd6, 4'd3, 0, gnt, rv, data, lat, bn, ok);
      if (ok) begin
         exp_ops++;
         n_cmp++;
         if (data !== 32'd7 || gnt !== 2'b10 || rv !== 2'b10 || lat !== 4) begin
            n_bad++;
            $display("FAIL div: data=%0d gnt=%b rv=%b lat=%0d, required 7/10/10/4", data, gnt, rv, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a0, b0, a1, b1;
      int k;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      req_a[31:0] = a0; req_b[31:0] = b0; req_op[3:0] = 4'd0;
      rsp_ready = 2'b00;
      req_valid[0] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (req_ready == 2'b00 && k < 20);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_a[63:32] = a1; req_b[63:32] = b1; req_op[7:4] = 4'd4;
      req_valid[1] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (rsp_valid == 2'b00 && k < 20);
      rsp_ready[1] = 1'b1;  // ready from the non-owner must be ignored
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 2'b01 || rsp_data !== a0 + b0 || req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy=%b, required 01/%h/00", i, rsp_valid,
                     rsp_data, req_ready, a0 + b0);
         end
         @(negedge clk);
      end
      rsp_ready = 2'b11;
      @(posedge clk);
      exp_ops++;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL bp_release: rdy=%b vld=%b, required 10/00", req_ready, rsp_valid);
      end
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (rsp_valid == 2'b00 && k < 20);
      n_cmp++;
      if (rsp_valid !== 2'b10 || rsp_data !== (a1 & b1)) begin
         n_bad++;
         $display("FAIL bp_req1: vld=%b data=%h, required 10/%h", rsp_valid, rsp_data, a1 & b1);
      end
      @(posedge clk);
      #1;
      exp_ops++;
      n_cmp++;
      if (ops_done !== 4'(exp_ops)) begin
         n_bad++;
         $display("FAIL bp_ops: ops_done=%0d, required %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [1:0] gnt, rv; logic [31:0] data; int lat, bn; bit ok;
      bit seen;
      int k;
      req_a[31:0] = $urandom | 32'h1; req_b[31:0] = $urandom | 32'h1; req_op[3:0] = 4'd2;
      rsp_ready = 2'b11;
      req_valid[0] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (req_ready == 2'b00 && k < 20);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      #2 rst_n = 1'b0;
      exp_ops = 0;
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid, busy, ops_done} !== 9'd0 || rsp_data !== 32'd0 ||
          alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 4'd0) begin
         n_bad++;
         $display("FAIL midreset_clear: rdy=%b vld=%b busy=%b ops=%0d data=%h a=%h sel=%h, required zero",
                  req_ready, rsp_valid, busy, ops_done, rsp_data, alu_a, alu_sel);
      end
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) seen = 1'b1;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_no_rsp: rsp_valid seen=%b, required 0", seen);
      end
      @(posedge clk); #1;
      run_op(1, 32'd1, 32'd4, 4'd10, 0, gnt, rv, data, lat, bn, ok);
      if (!ok) return;
      exp_ops++;
      n_cmp++;
      if (data !== 32'd16 || gnt !== 2'b10 || ops_done !== 4'(exp_ops)) begin
         n_bad++;
         $display("FAIL midreset_after: data=%0d gnt=%b ops=%0d, required 16/10/%0d", data, gnt,
                  ops_done, exp_ops);
      end
   endtask

   task automatic test_wrap_and_sub();
      logic [1:0] gnt, rv; logic [31:0] data, a, b; logic [3:0] op; int lat, bn, r; bit ok;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         r = $urandom_range(0, 1);
         a = $urandom; b = $urandom; op = 4'($urandom);
         run_op(r, a, b, op, 0, gnt, rv, data, lat, bn, ok);
         if (!ok) return;
         exp_ops++;
         n_cmp++;
         if (data !== alu_model(a, b, op) || ops_done !== 4'(exp_ops)) begin
            n_bad++;
            $display("FAIL wrap_op[%0d]: data=%h ops=%0d, required %h/%0d", i, data, ops_done,
                     alu_model(a, b, op), exp_ops % 16);
         end
      end
      n_cmp++;
      if (ops_done !== 4'd0) begin
         n_bad++;
         $display("FAIL wrap_zero: ops_done=%0d, required 0", ops_done);
      end
      run_op(0, 32'd3, 32'd5, 4'd1, 0, gnt, rv, data, lat, bn, ok);
      if (!ok) return;
      exp_ops++;
      n_cmp++;
      if (data !== 32'hFFFF_FFFE) begin
         n_bad++;
         $display("FAIL sub_data: got %h, required fffffffe", data);
      end
   endtask

   task automatic test_random();
      logic [1:0] gnt, rv; logic [31:0] data, a, b; logic [3:0] op; int lat, bn, r, hold; bit ok;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 1);
         a = $urandom; b = $urandom; op = 4'($urandom);
         hold = $urandom_range(0, 3);
         rsp_ready[1-r] = 1'($urandom);
         run_op(r, a, b, op, hold, gnt, rv, data, lat, bn, ok);
         if (!ok) return;
         exp_ops++;
         n_cmp++;
         if (gnt !== (2'b01 << r) || rv !== (2'b01 << r) || lat !== exp_lat(op) ||
             data !== alu_model(a, b, op) || ops_done !== 4'(exp_ops)) begin
            n_bad++;
            $display("FAIL rand[%0d]: r=%0d op=%0d gnt=%b rv=%b lat=%0d data=%h ops=%0d, required lat=%0d data=%h ops=%0d",
                     i, r, op, gnt, rv, lat, data, ops_done, exp_lat(op), alu_model(a, b, op),
                     exp_ops % 16);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00; rsp_ready = 2'b00;
      req_a = '0; req_b = '0; req_op = '0;
      @(posedge clk);
      test_reset();
      test_basic_add();
      test_round_robin();
      test_muldiv();
      test_backpressure();
      test_reset_mid_exec();
      test_wrap_and_sub();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
